// File: rtl/sar_search_pkg.sv
// Shared definitions for blocks that talk to an external l/e/g magnitude comparator.
package sar_search_pkg;

    // Search controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PROBE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Comparator flag patterns, packed as {l, e, g}
    localparam logic [2:0] FLAG_L = 3'b100;
    localparam logic [2:0] FLAG_E = 3'b010;
    localparam logic [2:0] FLAG_G = 3'b001;

    // True when exactly one comparator flag is asserted
    function automatic logic flags_one_hot(input logic [2:0] flags);
        return (flags == FLAG_L) || (flags == FLAG_E) || (flags == FLAG_G);
    endfunction

endpackage

// File: rtl/sar_search.sv
// Binary-search initiator: drives a trial value into an external comparator,
// reads back l/e/g and narrows [lo, hi] until the hidden operand is located.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CMP_LAT = 0,
    localparam int STEPW  = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    input  logic             l,
    input  logic             e,
    input  logic             g,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [STEPW-1:0] steps
);

    // Bounds carry one extra bit so lo can reach 2^WIDTH and hi can reach -1.
    localparam logic [WIDTH:0] HI_INIT = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] LO_INIT = '0;

    localparam int WCW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((CMP_LAT > 0) ? CMP_LAT - 1 : 0);

    // After a new trial is issued, go straight to sampling when the comparator is combinational.
    localparam logic [1:0] ST_AFTER = (CMP_LAT == 0) ? ST_PROBE : ST_WAIT;

    function automatic logic [WIDTH-1:0] mid_of(input logic [WIDTH:0] lo_v, input logic [WIDTH:0] hi_v);
        logic [WIDTH:0] span;
        logic [WIDTH:0] mid;
        span = hi_v - lo_v;
        mid  = lo_v + (span >> 1);
        return mid[WIDTH-1:0];
    endfunction

    localparam logic [WIDTH-1:0] TRIAL_INIT = mid_of(LO_INIT, HI_INIT);

    logic [1:0]     state;
    logic [WIDTH:0] lo;
    logic [WIDTH:0] hi;
    logic [WCW-1:0] wait_cnt;

    logic [2:0]     flags;
    logic [WIDTH:0] trial_ext;
    logic [WIDTH:0] lo_up;
    logic [WIDTH:0] hi_dn;
    logic           l_exhausted;
    logic           g_exhausted;

    // Candidate bound updates for the current probe; exhaustion is judged on the
    // unwrapped values so hi going to -1 never looks like a large positive bound.
    always_comb begin
        flags       = {l, e, g};
        trial_ext   = {1'b0, trial};
        lo_up       = trial_ext + 1'b1;
        hi_dn       = trial_ext - 1'b1;
        l_exhausted = (lo_up > hi);
        g_exhausted = (trial_ext == lo);
    end

    // Search state machine and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            trial    <= '0;
            result   <= '0;
            steps    <= '0;
            found    <= 1'b0;
            err      <= 1'b0;
            lo       <= '0;
            hi       <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lo       <= LO_INIT;
                        hi       <= HI_INIT;
                        steps    <= '0;
                        found    <= 1'b0;
                        err      <= 1'b0;
                        trial    <= TRIAL_INIT;
                        wait_cnt <= '0;
                        state    <= ST_AFTER;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_PROBE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_PROBE: begin
                    steps    <= steps + 1'b1;
                    wait_cnt <= '0;
                    case (flags)
                        FLAG_E: begin
                            result <= trial;
                            found  <= 1'b1;
                            state  <= ST_DONE;
                        end
                        FLAG_L: begin
                            lo <= lo_up;
                            if (l_exhausted) begin
                                found <= 1'b0;
                                state <= ST_DONE;
                            end else begin
                                trial <= mid_of(lo_up, hi);
                                state <= ST_AFTER;
                            end
                        end
                        FLAG_G: begin
                            hi <= hi_dn;
                            if (g_exhausted) begin
                                found <= 1'b0;
                                state <= ST_DONE;
                            end else begin
                                trial <= mid_of(lo, hi_dn);
                                state <= ST_AFTER;
                            end
                        end
                        default: begin
                            err   <= ~flags_one_hot(flags);
                            found <= 1'b0;
                            state <= ST_DONE;
                        end
                    endcase
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are pure state decodes, so they drop together with the done pulse.
    always_comb begin
        busy = (state == ST_PROBE) || (state == ST_WAIT);
        done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_sar_search.sv
// Directed self-checking bench for sar_search: one combinational-comparator instance
// and one instance behind a two-cycle comparator pipe.
module tb_sar_search;

    logic clk = 1'b0;

    logic       rst0 = 1'b1;
    logic       start0 = 1'b0;
    logic [7:0] trial0;
    logic       l0, e0, g0;
    logic       busy0, done0, found0, err0;
    logic [7:0] result0;
    logic [3:0] steps0;
    logic [7:0] target0 = 8'd0;
    logic [1:0] mode0 = 2'd0;

    logic       rst2 = 1'b1;
    logic       start2 = 1'b0;
    logic [7:0] trial2;
    logic       l2, e2, g2;
    logic       busy2, done2, found2, err2;
    logic [7:0] result2;
    logic [3:0] steps2;
    logic [7:0] target2 = 8'd100;
    logic [2:0] raw2;
    logic [2:0] pipe2a = 3'b000;
    logic [2:0] pipe2b = 3'b000;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [7:0] seqCap[$];
    logic [7:0] expSeq[$];
    int         cycCap;
    logic       capFound, capErr;
    logic [7:0] capResult;
    logic [3:0] capSteps;

    sar_search #(.WIDTH(8), .CMP_LAT(0)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .trial(trial0),
        .l(l0), .e(e0), .g(g0), .busy(busy0), .done(done0),
        .found(found0), .err(err0), .result(result0), .steps(steps0)
    );

    sar_search #(.WIDTH(8), .CMP_LAT(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .trial(trial2),
        .l(l2), .e(e2), .g(g2), .busy(busy2), .done(done2),
        .found(found2), .err(err2), .result(result2), .steps(steps2)
    );

    always #5 clk = ~clk;

    // Comparator for dut0: mode 0 honest, 1 always l, 2 always g, 3 l and e together
    always_comb begin
        l0 = 1'b0;
        e0 = 1'b0;
        g0 = 1'b0;
        case (mode0)
            2'd0: begin
                l0 = (trial0 < target0);
                e0 = (trial0 == target0);
                g0 = (trial0 > target0);
            end
            2'd1: l0 = 1'b1;
            2'd2: g0 = 1'b1;
            default: begin
                l0 = 1'b1;
                e0 = 1'b1;
            end
        endcase
    end

    // Comparator for dut2, widened cell followed by a two-stage latency pipe
    always_comb begin
        raw2 = {(trial2 < target2), (trial2 == target2), (trial2 > target2)};
    end

    always @(posedge clk) begin
        pipe2a <= raw2;
        pipe2b <= pipe2a;
    end

    assign {l2, e2, g2} = pipe2b;

    // Global time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkSeq(input string tag);
        logic [31:0] obs;
        checkOutput({tag, "_len"}, seqCap.size(), expSeq.size());
        for (int i = 0; i < expSeq.size(); i++) begin
            obs = (i < seqCap.size()) ? {24'd0, seqCap[i]} : 32'hFFFF_FFFF;
            checkOutput($sformatf("%s[%0d]", tag, i), obs, {24'd0, expSeq[i]});
        end
    endtask

    // Run one search on dut0 and capture trial sequence, latency and final outputs
    task automatic applyStimulus0(input logic [7:0] tgt, input logic [1:0] mode);
        int cyc;
        @(negedge clk);
        target0 = tgt;
        mode0 = mode;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1;
        seqCap.delete();
        while (!done0 && cyc < 200) begin
            if (busy0 && (seqCap.size() == 0 || seqCap[$] != trial0)) seqCap.push_back(trial0);
            @(negedge clk);
            cyc++;
        end
        cycCap = cyc;
        checkOutput("dut0_done_seen", done0, 1'b1);
        capFound = found0;
        capErr = err0;
        capResult = result0;
        capSteps = steps0;
        @(negedge clk);
        checkOutput("dut0_done_one_cycle", done0, 1'b0);
        checkOutput("dut0_busy_after_done", busy0, 1'b0);
    endtask

    // Run one search on dut2, optionally pulsing start again while busy
    task automatic applyStimulus2(input logic [7:0] tgt, input int extraStartAt);
        int cyc;
        @(negedge clk);
        target2 = tgt;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        seqCap.delete();
        while (!done2 && cyc < 400) begin
            if (busy2 && (seqCap.size() == 0 || seqCap[$] != trial2)) seqCap.push_back(trial2);
            start2 = (cyc == extraStartAt);
            @(negedge clk);
            cyc++;
        end
        start2 = 1'b0;
        cycCap = cyc;
        checkOutput("dut2_done_seen", done2, 1'b1);
        capFound = found2;
        capErr = err2;
        capResult = result2;
        capSteps = steps2;
        @(negedge clk);
        checkOutput("dut2_done_one_cycle", done2, 1'b0);
    endtask

    initial begin
        int cnt;
        int doneSeen;

        // Reset state of both instances
        repeat (2) @(negedge clk);
        checkOutput("rst_trial0", trial0, 0);
        checkOutput("rst_busy0", busy0, 0);
        checkOutput("rst_done0", done0, 0);
        checkOutput("rst_found0", found0, 0);
        checkOutput("rst_err0", err0, 0);
        checkOutput("rst_result0", result0, 0);
        checkOutput("rst_steps0", steps0, 0);
        checkOutput("rst_busy2", busy2, 0);
        checkOutput("rst_steps2", steps2, 0);
        rst0 = 1'b0;
        rst2 = 1'b0;

        // Target at the first midpoint
        applyStimulus0(8'd127, 2'd0);
        expSeq = '{8'd127};
        checkSeq("t127_seq");
        checkOutput("t127_latency", cycCap, 2);
        checkOutput("t127_found", capFound, 1);
        checkOutput("t127_result", capResult, 127);
        checkOutput("t127_steps", capSteps, 1);

        // Lowest target walks hi down to zero
        applyStimulus0(8'd0, 2'd0);
        expSeq = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};
        checkSeq("t0_seq");
        checkOutput("t0_found", capFound, 1);
        checkOutput("t0_result", capResult, 0);
        checkOutput("t0_steps", capSteps, 8);
        checkOutput("t0_latency", cycCap, 9);

        // Highest target walks lo up to the top
        applyStimulus0(8'd255, 2'd0);
        expSeq = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
        checkSeq("t255_seq");
        checkOutput("t255_found", capFound, 1);
        checkOutput("t255_result", capResult, 255);
        checkOutput("t255_steps", capSteps, 9);

        // Comparator never reports equal (always l): lo passes 2^WIDTH-1
        applyStimulus0(8'd0, 2'd1);
        expSeq = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
        checkSeq("alwaysL_seq");
        checkOutput("alwaysL_found", capFound, 0);
        checkOutput("alwaysL_err", capErr, 0);
        checkOutput("alwaysL_steps", capSteps, 9);
        checkOutput("alwaysL_result_held", capResult, 255);
        checkOutput("alwaysL_latency", cycCap, 10);

        // Comparator always g: hi drops to -1 after probing zero
        applyStimulus0(8'd0, 2'd2);
        expSeq = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};
        checkSeq("alwaysG_seq");
        checkOutput("alwaysG_found", capFound, 0);
        checkOutput("alwaysG_err", capErr, 0);
        checkOutput("alwaysG_steps", capSteps, 8);

        // Illegal flags l=e=1 on the first probe
        applyStimulus0(8'd0, 2'd3);
        checkOutput("illegal_err", capErr, 1);
        checkOutput("illegal_found", capFound, 0);
        checkOutput("illegal_steps", capSteps, 1);
        checkOutput("illegal_latency", cycCap, 2);
        checkOutput("illegal_err_held", err0, 1);

        // Legal search afterwards clears the error
        applyStimulus0(8'd42, 2'd0);
        expSeq = '{8'd127, 8'd63, 8'd31, 8'd47, 8'd39, 8'd43, 8'd41, 8'd42};
        checkSeq("t42_seq");
        checkOutput("t42_err", capErr, 0);
        checkOutput("t42_found", capFound, 1);
        checkOutput("t42_result", capResult, 42);

        // Pipelined comparator: reset during the third probe aborts the search
        @(negedge clk);
        target2 = 8'd100;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cnt = 0;
        while (trial2 != 8'd95 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("lat2_reach_third_probe", trial2, 95);
        checkOutput("lat2_steps_before_rst", steps2, 2);
        rst2 = 1'b1;
        @(negedge clk);
        checkOutput("midrst_trial", trial2, 0);
        checkOutput("midrst_busy", busy2, 0);
        checkOutput("midrst_done", done2, 0);
        checkOutput("midrst_found", found2, 0);
        checkOutput("midrst_err", err2, 0);
        checkOutput("midrst_result", result2, 0);
        checkOutput("midrst_steps", steps2, 0);
        rst2 = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done2) doneSeen++;
        end
        checkOutput("midrst_no_done", doneSeen, 0);

        // Fresh pipelined run with a stray start pulse while busy
        applyStimulus2(8'd100, 4);
        expSeq = '{8'd127, 8'd63, 8'd95, 8'd111, 8'd103, 8'd99, 8'd101, 8'd100};
        checkSeq("lat2_seq");
        checkOutput("lat2_latency", cycCap, 25);
        checkOutput("lat2_found", capFound, 1);
        checkOutput("lat2_result", capResult, 100);
        checkOutput("lat2_steps", capSteps, 8);
        checkOutput("lat2_err", capErr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
